// File: rtl/resp_bus.sv
// resp_bus: slave->master response channel, a fully registered two-entry skid buffer that tags each accepted word.
// Latency: one edge from accept to resp_valid; backpressure: resp_ready drops only once both entries hold a word.
module resp_bus #(
  parameter int DATA_W = 24,
  parameter int SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] slave_resp_data,
  input  logic              slave_resp_valid,
  output logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [SEQ_W-1:0]  resp_seq,
  output logic              resp_valid,
  input  logic              master_ready,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [SEQ_W-1:0]  main_seq_q, main_seq_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic [SEQ_W-1:0]  skid_seq_q, skid_seq_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic              in_acc, out_acc;

  assign in_acc  = slave_resp_valid & rdy_q;
  assign out_acc = vld_q & master_ready;

  always_comb begin
    state_d    = state_q;
    main_dat_d = main_dat_q;
    main_seq_d = main_seq_q;
    skid_dat_d = skid_dat_q;
    skid_seq_d = skid_seq_q;
    seq_cnt_d  = in_acc ? seq_cnt_q + SEQ_W'(1) : seq_cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          main_dat_d = slave_resp_data;
          main_seq_d = seq_cnt_q;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          main_dat_d = slave_resp_data;
          main_seq_d = seq_cnt_q;
        end else if (in_acc) begin
          skid_dat_d = slave_resp_data;
          skid_seq_d = seq_cnt_q;
          state_d    = TWO;
        end else if (out_acc) begin
          state_d    = EMPTY;
        end
      end
      TWO: begin
        // resp_ready is low here, so only the drain into main can happen
        if (out_acc) begin
          main_dat_d = skid_dat_q;
          main_seq_d = skid_seq_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    vld_d = (state_d != EMPTY);
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q    <= EMPTY;
      main_dat_q <= '0;
      main_seq_q <= '0;
      skid_dat_q <= '0;
      skid_seq_q <= '0;
      seq_cnt_q  <= '0;
      vld_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_dat_q <= main_dat_d;
      main_seq_q <= main_seq_d;
      skid_dat_q <= skid_dat_d;
      skid_seq_q <= skid_seq_d;
      seq_cnt_q  <= seq_cnt_d;
      vld_q      <= vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign resp_ready = rdy_q;
  assign resp_valid = vld_q;
  assign resp_data  = main_dat_q;
  assign resp_seq   = main_seq_q;
  assign occupancy  = state_q;

endmodule

// File: tb/tb_resp_bus.sv
// Bench for resp_bus: scoreboard of accepted words checked against delivered words, plus directed state checks.
module tb_resp_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] slave_resp_data;
  logic        slave_resp_valid;
  logic        resp_ready;
  logic [23:0] resp_data;
  logic [7:0]  resp_seq;
  logic        resp_valid;
  logic        master_ready;
  logic [1:0]  occupancy;

  resp_bus #(.DATA_W(24), .SEQ_W(8)) dut (
    .clk              (clk),
    .RST              (rst),
    .slave_resp_data  (slave_resp_data),
    .slave_resp_valid (slave_resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .resp_seq         (resp_seq),
    .resp_valid       (resp_valid),
    .master_ready     (master_ready),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [23:0] d;
    logic [7:0]  s;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  exp_seq = 8'd0;
  int          n_out = 0;
  logic [7:0]  last_seq = 8'd0;

  // Sample 1ns before each rising edge: pops compare delivered words, pushes stamp accepted ones.
  initial forever begin
    @(negedge clk);
    #4;
    if (rst) begin
      sb.delete();
      exp_seq = 8'd0;
    end else begin
      if (resp_valid && master_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", {8'd0, resp_data}, {8'd0, e.d});
          chk("out_seq", {24'd0, resp_seq}, {24'd0, e.s});
          n_out++;
          last_seq = resp_seq;
        end
      end
      if (slave_resp_valid && resp_ready) begin
        sb.push_back({slave_resp_data, exp_seq});
        exp_seq = exp_seq + 8'd1;
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int          out0;
  logic [23:0] held;

  initial begin
    rst              = 1'b1;
    slave_resp_valid = 1'b0;
    slave_resp_data  = 24'd0;
    master_ready     = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_ready", {31'd0, resp_ready}, 32'd0);
    chk("rst_data", {8'd0, resp_data}, 32'd0);
    chk("rst_seq", {24'd0, resp_seq}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, resp_ready}, 32'd1);
    chk("idle_valid", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid_later", {31'd0, resp_valid}, 32'd0);

    // Single word
    slave_resp_data  = 24'hA5A5A5;
    slave_resp_valid = 1'b1;
    master_ready     = 1'b1;
    @(posedge clk); #1;
    slave_resp_valid = 1'b0;
    slave_resp_data  = 24'd0;
    @(negedge clk);
    chk("single_valid", {31'd0, resp_valid}, 32'd1);
    chk("single_data", {8'd0, resp_data}, 32'h00A5A5A5);
    chk("single_seq", {24'd0, resp_seq}, 32'd0);
    chk("single_occ1", {30'd0, occupancy}, 32'd1);
    @(negedge clk);
    chk("single_valid_off", {31'd0, resp_valid}, 32'd0);
    chk("single_occ0", {30'd0, occupancy}, 32'd0);

    // Streaming, master always ready
    @(posedge clk); #1;
    out0 = n_out;
    for (int i = 1; i <= 10; i++) begin
      slave_resp_data  = 24'(i);
      slave_resp_valid = 1'b1;
      @(posedge clk); #1;
      chk("stream_ready", {31'd0, resp_ready}, 32'd1);
    end
    slave_resp_valid = 1'b0;
    drain("stream_drain");
    chk("stream_count", n_out - out0, 32'd10);

    // Skid under 3 cycles of backpressure
    @(posedge clk); #1;
    master_ready     = 1'b1;
    slave_resp_valid = 1'b1;
    slave_resp_data  = 24'h000100;
    repeat (3) begin
      @(posedge clk); #1;
      slave_resp_data = slave_resp_data + 24'd1;
    end
    chk("skid_occ1", {30'd0, occupancy}, 32'd1);
    master_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) held = resp_data;
      chk("skid_occ2", {30'd0, occupancy}, 32'd2);
      chk("skid_ready_low", {31'd0, resp_ready}, 32'd0);
      chk("skid_data_stable", {8'd0, resp_data}, {8'd0, held});
      slave_resp_data = slave_resp_data + 24'd1;
    end
    master_ready = 1'b1;
    @(posedge clk); #1;
    chk("skid_drain_occ", {30'd0, occupancy}, 32'd1);
    chk("skid_ready_back", {31'd0, resp_ready}, 32'd1);
    repeat (3) begin
      slave_resp_data = slave_resp_data + 24'd1;
      @(posedge clk); #1;
    end
    slave_resp_valid = 1'b0;
    drain("skid_drain");

    // Reset while full
    @(posedge clk); #1;
    master_ready     = 1'b0;
    slave_resp_valid = 1'b1;
    slave_resp_data  = 24'h000200;
    for (int i = 0; i < 10 && occupancy != 2'd2; i++) begin
      @(posedge clk); #1;
      slave_resp_data = slave_resp_data + 24'd1;
    end
    chk("mid_occ2", {30'd0, occupancy}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_occ", {30'd0, occupancy}, 32'd0);
    chk("mid_ready", {31'd0, resp_ready}, 32'd0);
    slave_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    slave_resp_data  = 24'h0BEEF0;
    slave_resp_valid = 1'b1;
    @(posedge clk); #1;
    slave_resp_valid = 1'b0;
    chk("mid_after_seq", {24'd0, resp_seq}, 32'd0);
    chk("mid_after_data", {8'd0, resp_data}, 32'h000BEEF0);
    master_ready = 1'b1;
    drain("mid_drain");

    // Tag wrap across 258 words
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    master_ready = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 258; i++) begin
      slave_resp_data  = 24'h300 + 24'(i);
      slave_resp_valid = 1'b1;
      @(posedge clk); #1;
    end
    slave_resp_valid = 1'b0;
    drain("wrap_drain");
    chk("wrap_count", n_out - out0, 32'd258);
    chk("wrap_last_seq", {24'd0, last_seq}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
